// File: rtl/bcd_display_scanner.sv
// Binary-to-BCD double-dabble converter feeding a 4-digit time-multiplexed display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits at the scan output.
module bcd_display_scanner #(
    parameter int WIDTH       = 14,
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] value,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       an,
    output logic [3:0]       bcd,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, CONVERT = 2'd1, COMMIT = 2'd2} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(REFRESH_DIV + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [15:0]      scratch_q, scratch_d, adj;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [15:0]      digits_q, digits_d;
    logic             ovf_q, ovf_d, done_q, done_d;
    logic [RW-1:0]    ref_q, ref_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q, an_d, bcd_q, bcd_d;
    logic             over, wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            digits_q  <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            ref_q     <= '0;
            idx_q     <= '0;
            an_q      <= 4'b1110;
            bcd_q     <= 4'h0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            digits_q  <= digits_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            ref_q     <= ref_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            bcd_q     <= bcd_d;
        end
    end

    always_comb begin
        over      = 32'(value) > 32'd9999;
        adj       = scratch_q;
        for (int i = 0; i < 4; i++) begin
            if (scratch_q[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
        end
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        digits_d  = digits_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    if (over) begin
                        digits_d = 16'hFFFF;
                        ovf_d    = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        shift_d   = value;
                        scratch_d = '0;
                        cnt_d     = '0;
                        state_d   = CONVERT;
                    end
                end
            end
            CONVERT: begin
                {scratch_d, shift_d} = {adj, shift_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = COMMIT;
                    done_d  = 1'b1;   // registered, so it is high during COMMIT
                end
            end
            COMMIT: begin
                digits_d = scratch_q;
                ovf_d    = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Scan output is built from the next digit value so a commit shows up one cycle later.
        wrap  = (ref_q == REF_LAST);
        ref_d = wrap ? '0 : ref_q + 1'b1;
        idx_d = wrap ? idx_q + 2'd1 : idx_q;
        an_d  = ~(4'b0001 << idx_d);
        bcd_d = digits_d[{idx_d, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_d != 2'd0 && (digits_d >> {idx_d, 2'b00}) == 16'h0000)
            bcd_d = 4'hF;
`endif
    end

    assign busy      = (state_q == CONVERT);
    assign done      = done_q;
    assign ovf       = ovf_q;
    assign an        = an_q;
    assign bcd       = bcd_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner: directed loads, display scan and reset behaviour.
module tb_bcd_display_scanner;
  localparam int WIDTH = 14;
  localparam int DIV   = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] LZ = 4'hF;
`else
  localparam logic [3:0] LZ = 4'h0;
`endif

  logic clk, rst_n, load, busy, done, ovf;
  logic [WIDTH-1:0] value;
  logic [3:0] an, bcd;
  logic [1:0] dbg_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int n_push = 0;
  logic [16:0] exp_q[$];
  int exp_cyc_q[$];

  bcd_display_scanner #(.WIDTH(WIDTH), .REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .busy(busy), .done(done),
    .ovf(ovf), .an(an), .bcd(bcd), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] an_exp(input int i);
    return ~(4'b0001 << i);
  endfunction

  function automatic int an_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // driver tasks
  task automatic pulse_load(input logic [WIDTH-1:0] v, output int n);
    @(posedge clk); #1;
    value = v;
    load = 1'b1;
    n = cyc;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic run_vec(input logic [WIDTH-1:0] v, input logic [15:0] disp, input logic ovfe);
    int n;
    int nb;
    pulse_load(v, n);
    exp_q.push_back({ovfe, disp});
    exp_cyc_q.push_back(ovfe ? n + 1 : n + WIDTH + 1);
    n_push++;
    if (!ovfe) begin
      nb = 0;
      repeat (WIDTH + 1) begin
        @(negedge clk);
        if (busy) nb++;
      end
      check("busy_len", nb, WIDTH);
    end
    repeat (WIDTH + 4 * DIV + 8) @(posedge clk);
  endtask

  // monitor / scoreboard
  initial begin
    logic [16:0] e;
    logic [15:0] seen;
    int ecyc;
    int idx;
    int ok;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          ecyc = exp_cyc_q.pop_front();
          check("done_cycle", cyc, ecyc);
          @(negedge clk);
          check("done_width", done, 0);
          check("ovf", ovf, e[16]);
          idx = an_idx(an);
          ok = (idx >= 0) ? 1 : 0;
          if (idx < 0) idx = 0;
          check("commit_vis", bcd, e[idx*4 +: 4]);
          seen = 16'h0;
          for (int k = 0; k < 4 * DIV; k++) begin
            if (k > 0) @(negedge clk);
            if (an_idx(an) < 0) ok = 0;
            else seen[an_idx(an)*4 +: 4] = bcd;
          end
          check("an_onehot", ok, 1);
          check("digits", seen, e[15:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    int n;
    rst_n = 1'b0;
    load = 1'b0;
    value = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) begin
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_state", dbg_state, 0);
      end
      check("scan_an", an, an_exp(k / 4));
      check("scan_bcd", bcd, (k / 4 == 0) ? 4'h0 : LZ);
    end

    run_vec(14'd1234, 16'h1234, 1'b0);
    run_vec(14'd9999, 16'h9999, 1'b0);
    run_vec(14'd10000, 16'hFFFF, 1'b1);
    check("ovf_sticky", ovf, 1);
    run_vec(14'd7, {LZ, LZ, LZ, 4'h7}, 1'b0);
    run_vec(14'd0, {LZ, LZ, LZ, 4'h0}, 1'b0);
    run_vec(14'd1005, 16'h1005, 1'b0);

    // second load lands while the first conversion is running and must be dropped
    pulse_load(14'd1234, n);
    exp_q.push_back({1'b0, 16'h1234});
    exp_cyc_q.push_back(n + WIDTH + 1);
    n_push++;
    @(posedge clk);
    pulse_load(14'd5678, n);
    repeat (WIDTH + 4 * DIV + 12) @(posedge clk);

    // asynchronous reset in the middle of a conversion
    pulse_load(14'd4321, n);
    repeat (4) @(posedge clk);
    #2;
    check("midconv_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_an", an, 4'b1110);
    check("arst_bcd", bcd, 4'h0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (WIDTH + 10) @(posedge clk);
    @(negedge clk);
    check("post_rst_busy", busy, 0);

    check("pending", exp_q.size(), 0);
    check("done_count", done_cnt, n_push);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Upstream feeder for the team's BCD-to-7-segment decoder on the 4-digit multiplexed display.
- Converts a binary calculator result to four BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the digits: drives one 4-bit BCD nibble plus the matching active-low anode enable, rotating at a programmable refresh rate.
- The decoder consumes `bcd` combinationally; any nibble value above 9 decodes to blank.

Parameters:
- WIDTH, 14, binary input width; values above 9999 are treated as overflow.
- REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz digit rate at 100 MHz).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- value  input  WIDTH  unsigned binary result to display.
- load  input  1  one-cycle strobe; capture `value` and start conversion.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the new digits are committed to the display.
- ovf  output  1  sticky overflow of the last load (value > 9999).
- an  output  4  digit anodes, active-low, one-hot-low; an[0] = rightmost (ones) digit.
- bcd  output  4  BCD nibble for the active digit; 4'hF means blank.

Behaviour:
- Reset (async assert, sync deassert by the system) sets:
  - state IDLE, busy=0, done=0, ovf=0;
  - display digits all 0, scan index 0, refresh counter 0;
  - an=4'b1110, bcd=4'h0.
- FSM has three states: IDLE, CONVERT, COMMIT.
- IDLE + load, value <= 9999:
  - latch value into the shift register and clear the 16-bit BCD scratch;
  - go to CONVERT; busy=1 on the next cycle.
- IDLE + load, value > 9999:
  - no conversion; display digits all set to 4'hF (blank); ovf=1; done pulses the next cycle; stay IDLE.
- CONVERT:
  - exactly WIDTH cycles;
  - each cycle, every BCD nibble >= 5 gets +3, then {scratch, shift} shifts left by 1;
  - after the WIDTH-th shift, go to COMMIT.
- COMMIT (1 cycle):
  - copy scratch into the display digit registers atomically; ovf=0; done=1 for this cycle;
  - busy=0 from the next cycle; return to IDLE.
- Latency: load at cycle N gives done at cycle N+WIDTH+1; new digits visible on `bcd` from N+WIDTH+2.
- The display shows the previous digits throughout conversion; no partial value is ever displayed.
- load while busy=1 is ignored (no queuing); load in the COMMIT cycle is also ignored.
- Scan:
  - refresh counter counts 0..REFRESH_DIV-1 and wraps;
  - on wrap, scan index increments mod 4 (3 wraps to 0);
  - an and bcd are registered and both change on the cycle after the wrap, so they are never mismatched;
  - an values: index 0 -> 4'b1110, 1 -> 4'b1101, 2 -> 4'b1011, 3 -> 4'b0111.
- Scanning runs continuously and independently of the FSM; a commit takes effect at the next bcd register update, not at a slot boundary.
- Reset mid-conversion aborts it; the display returns to 0000.
- REFRESH_DIV=1 is legal: the index advances every cycle.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when a digit is 0 and all higher-order digits are 0, bcd drives 4'hF for that slot, so the digit is blank. The ones digit is never blanked, so value 0 shows "   0". Blanking is evaluated at the scan output, so display registers still hold 0.
- Undefined: all four digits are always shown, including leading zeros.

Test Plan:
- Reset, REFRESH_DIV=4, no load -> an cycles 1110,1101,1011,0111 every 4 clocks; bcd=0 in every slot; busy=0, ovf=0.
- load value=1234 -> busy=1 for 14 cycles; done pulses 15 cycles after load; slots 0..3 then show bcd 4,3,2,1.
- load 9999 then 10000 -> first gives digits 9,9,9,9 with ovf=0; second gives ovf=1, all slots bcd=F, done one cycle after load.
- load 1234, then load 5678 three cycles later -> second load ignored; final digits 4,3,2,1, exactly one done pulse.
- Assert rst_n=0 mid-conversion of 4321 -> an=1110, bcd=0, busy=0 immediately (asynchronous); no done afterwards.
- With LEADING_ZERO_BLANK_EN: load 7 -> slots show 7,F,F,F; load 0 -> slots show 0,F,F,F; load 1005 -> slots show 5,0,0,1. Without the macro, load 7 -> slots show 7,0,0,0.
